fpu_float_sqrt_iterative: RTL
=============================

Name: fpu_float_sqrt_iterative

Overview:
Multi-cycle single-precision square root unit with valid/ready handshakes on both sides. It sits directly upstream of the FPU rounding stage. It produces an unrounded result (sign/exponent/23-bit mantissa) plus 3 guard bits {guard, round, sticky}, and passes the rounding mode through unchanged. It replaces the untimed sqrt model in hardware, adds guard/sticky generation, and defines behaviour for special cases.

Parameters:
BITS_PER_CYCLE, 1, root bits resolved per cycle; legal values 1, 2, 13, 26; any other value is a compile-time error.

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  operand valid
in_ready  out  1  unit can accept an operand
in_number  in  32  operand, fpu_float_fields_t
in_round_mode  in  fpu_round_mode_t  rounding mode, captured with the operand
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_number  out  32  unrounded result, fpu_float_fields_t
out_guard_bits  out  3  {guard, round, sticky}, fpu_guard_bits_t
out_round_mode  out  fpu_round_mode_t  captured rounding mode
out_invalid  out  1  invalid-operation flag

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
- All outputs are registered. After a reset edge: state=IDLE, in_ready=1, out_valid=0, out_number/out_guard_bits/out_invalid=0.
- States and transitions:
  - IDLE -> SQRT on in_valid&&in_ready for a normal operand.
  - IDLE -> DONE for a special operand.
  - SQRT -> DONE after 26/BITS_PER_CYCLE cycles.
  - DONE -> IDLE on out_valid&&out_ready.
- in_ready=1 only in IDLE. No overlap between operations.
- Latency, for an accept at edge T:
  - Special operand: out_valid rises after edge T+1.
  - Normal operand: out_valid rises after edge T+1+26/BITS_PER_CYCLE.
- Output holding: out_* stay stable while out_valid && !out_ready.
- Special cases (decided in IDLE, priority order):
  1. Exponent 0xFF with mantissa !=0 -> FPU_FLOAT_NAN, invalid=0.
  2. Sign=1 and not zero/denormal (includes -Inf) -> FPU_FLOAT_NAN, invalid=1.
  3. +Inf -> +Inf.
  4. Zero or denormal (denormals are flushed) -> signed zero with the input sign.
  5. Guard bits for every special case = 000.
- Normal operand, exponent E:
  - Radicand mantissa m = {1, mantissa}.
  - If E is even, m is shifted left by 1, so the radicand lies in [2,4).
  - Result exponent = (E + 126 + E[0]) >> 1, computed in 9 bits. Overflow and underflow are impossible.
  - Result sign = 0.
- Root computation:
  - Restoring digit-by-digit on a 52-bit fixed-point radicand (2 integer bits, 50 fraction bits).
  - Each iteration consumes 2 radicand bits and yields 1 root bit, for a 26-bit root r.
  - r[25] is always 1. mantissa = r[24:2], guard = r[1], round = r[0], sticky = (final remainder != 0).
  - The remainder register is 28 bits wide and must not overflow.
- Reset mid-operation: abort the operation, return to IDLE, drop the result. No out_valid for the aborted operand.
- in_number and in_round_mode are ignored when in_ready=0.

Decomposition:
- Shared package fpu gains:
  - fpu_sqrt_state_t enum (IDLE/SQRT/DONE).
  - FPU_SQRT_ROOT_BITS=26.
  - fpu_sqrt_step_t struct {remainder[27:0], root[25:0], radicand[51:0]}.
- Existing fpu_float_fields_t, fpu_guard_bits_t, fpu_round_mode_t and FPU_FLOAT_NAN are reused.
- One combinational sub-module, fpu_float_sqrt_step: a single restoring iteration (shift in 2 radicand bits, trial-subtract (root<<2)|1, set root bit). It is instantiated BITS_PER_CYCLE times in a chain.

Test Plan:
- 0x40800000 (4.0), BITS_PER_CYCLE=1 -> out_number 0x40000000, guard 3'b000, invalid 0, out_valid 27 cycles after accept.
- 0x40000000 (2.0) -> 0x3FB504F3, guard 3'b001; 0x3E800000 (0.25) -> 0x3F000000, guard 3'b000.
- Special cases, each valid 1 cycle after accept:
  - 0xBF800000 -> FPU_FLOAT_NAN, invalid 1.
  - 0x80000000 -> 0x80000000.
  - 0x7F800000 -> 0x7F800000.
  - 0x00000001 -> 0x00000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0; on out_ready=1 -> IDLE next cycle, then a back-to-back operand is accepted.
- Reset at cycle 10 of a 26-cycle operation -> out_valid never asserts, in_ready=1 after the reset edge; next operand 0x40800000 completes correctly.
- Random normal operands, BITS_PER_CYCLE in {1,2,13,26}: results bit-exact across all parameter values; verify against the exact root, requiring r² ≤ radicand < (r+1)², and sticky consistent with the remainder.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU types, constants and square-root iteration state
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } fpu_float_fields_t;

  typedef struct packed {
    logic guard;
    logic round;
    logic sticky;
  } fpu_guard_bits_t;

  typedef enum logic [2:0] {
    FPU_RNE = 3'd0,
    FPU_RTZ = 3'd1,
    FPU_RDN = 3'd2,
    FPU_RUP = 3'd3,
    FPU_RMM = 3'd4
  } fpu_round_mode_t;

  localparam fpu_float_fields_t FPU_FLOAT_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQRT = 2'd1,
    DONE = 2'd2
  } fpu_sqrt_state_t;

  localparam int FPU_SQRT_ROOT_BITS = 26;

  // One restoring-iteration snapshot: partial remainder, partial root and the
  // radicand bits not yet consumed (top two bits are the next digit pair).
  typedef struct packed {
    logic [27:0] remainder;
    logic [25:0] root;
    logic [51:0] radicand;
  } fpu_sqrt_step_t;

endpackage

// File: rtl/fpu_float_sqrt_step.sv
// rtl/fpu_float_sqrt_step.sv - one restoring square-root iteration
// Ports:
//   step_in  - iteration state before this root bit
//   step_out - iteration state after resolving one more root bit
module fpu_float_sqrt_step
  import fpu_pkg::*;
(
  input  fpu_sqrt_step_t step_in,
  output fpu_sqrt_step_t step_out
);

  logic [27:0] rem_shift;
  logic [27:0] trial;

  always_comb begin
    // The remainder never exceeds 2*root, so its top two bits are zero
    // before the shift and the truncation loses nothing.
    rem_shift = 28'({step_in.remainder, step_in.radicand[51:50]});
    trial     = {step_in.root, 2'b01};
    step_out.radicand = {step_in.radicand[49:0], 2'b00};
    if (rem_shift >= trial) begin
      step_out.remainder = rem_shift - trial;
      step_out.root      = 26'({step_in.root, 1'b1});
    end else begin
      step_out.remainder = rem_shift;
      step_out.root      = 26'({step_in.root, 1'b0});
    end
  end

endmodule

// File: rtl/fpu_float_sqrt_iterative.sv
// rtl/fpu_float_sqrt_iterative.sv - multi-cycle single-precision square root, unrounded output
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   in_valid/in_ready          - operand handshake; in_ready only while idle
//   in_number, in_round_mode   - operand and rounding mode, captured on accept
//   out_valid/out_ready        - result handshake; outputs held until accepted
//   out_number, out_guard_bits - unrounded result and {guard, round, sticky}
//   out_round_mode             - captured rounding mode
//   out_invalid                - invalid-operation flag
module fpu_float_sqrt_iterative
  import fpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  fpu_float_fields_t in_number,
  input  fpu_round_mode_t   in_round_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output fpu_float_fields_t out_number,
  output fpu_guard_bits_t   out_guard_bits,
  output fpu_round_mode_t   out_round_mode,
  output logic              out_invalid
);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
        BITS_PER_CYCLE == 13 || BITS_PER_CYCLE == 26)) begin : g_bad_param
    $error("BITS_PER_CYCLE must be 1, 2, 13 or 26");
  end

  localparam int         ITERS = FPU_SQRT_ROOT_BITS / BITS_PER_CYCLE;
  localparam logic [4:0] LAST  = 5'(ITERS - 1);

  fpu_sqrt_state_t   state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  fpu_sqrt_step_t    step_q, step_d;
  logic [7:0]        exp_q, exp_d;
  logic              special_q, special_d;
  fpu_float_fields_t special_num_q, special_num_d;
  logic              invalid_q, invalid_d;
  fpu_round_mode_t   rm_q, rm_d;

  logic              in_ready_d, out_valid_d, out_invalid_d;
  fpu_float_fields_t out_number_d;
  fpu_guard_bits_t   out_guard_d;
  fpu_round_mode_t   out_rm_d;

  // Operand decode
  logic              is_special, special_invalid;
  fpu_float_fields_t special_num;
  logic [8:0]        exp_sum;
  logic [7:0]        res_exp;
  fpu_sqrt_step_t    step_init;

  always_comb begin
    is_special      = 1'b1;
    special_invalid = 1'b0;
    special_num     = FPU_FLOAT_NAN;
    if (in_number.exponent == 8'hFF && in_number.mantissa != 23'd0) begin
      special_num = FPU_FLOAT_NAN;
    end else if (in_number.sign && in_number.exponent != 8'd0) begin
      special_invalid = 1'b1;
    end else if (in_number.exponent == 8'hFF) begin
      special_num = {1'b0, 8'hFF, 23'd0};
    end else if (in_number.exponent == 8'd0) begin
      special_num = {in_number.sign, 31'd0};
    end else begin
      is_special = 1'b0;
    end
  end

  // Odd exponents keep the radicand in [1,2); even ones double it into [2,4)
  // so the unbiased exponent becomes even and halves exactly.
  assign exp_sum = {1'b0, in_number.exponent} + 9'd126 + {8'd0, in_number.exponent[0]};
  assign res_exp = 8'(exp_sum >> 1);

  always_comb begin
    step_init.remainder = 28'd0;
    step_init.root      = 26'd0;
    step_init.radicand  = in_number.exponent[0] ? {2'b01, in_number.mantissa, 27'd0}
                                                : {1'b1, in_number.mantissa, 28'd0};
  end

  fpu_sqrt_step_t chain [0:BITS_PER_CYCLE];
  assign chain[0] = step_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    fpu_float_sqrt_step u_step (
      .step_in  (chain[g]),
      .step_out (chain[g+1])
    );
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    step_d        = step_q;
    exp_d         = exp_q;
    special_d     = special_q;
    special_num_d = special_num_q;
    invalid_d     = invalid_q;
    rm_d          = rm_q;
    out_valid_d   = out_valid;
    out_number_d  = out_number;
    out_guard_d   = out_guard_bits;
    out_rm_d      = out_round_mode;
    out_invalid_d = out_invalid;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          rm_d          = in_round_mode;
          special_d     = is_special;
          special_num_d = special_num;
          invalid_d     = special_invalid;
          exp_d         = res_exp;
          step_d        = step_init;
          cnt_d         = LAST;
          state_d       = is_special ? DONE : SQRT;
        end
      end
      SQRT: begin
        step_d = chain[BITS_PER_CYCLE];
        if (cnt_q == 5'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 5'd1;
      end
      DONE: begin
        // First DONE cycle loads the output registers; afterwards they hold
        // until the downstream handshake.
        if (!out_valid) begin
          out_valid_d = 1'b1;
          out_rm_d    = rm_q;
          if (special_q) begin
            out_number_d  = special_num_q;
            out_guard_d   = 3'b000;
            out_invalid_d = invalid_q;
          end else begin
            out_number_d  = {1'b0, exp_q, step_q.root[24:2]};
            out_guard_d   = {step_q.root[1], step_q.root[0], step_q.remainder != 28'd0};
            out_invalid_d = 1'b0;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 5'd0;
      step_q         <= '0;
      exp_q          <= 8'd0;
      special_q      <= 1'b0;
      special_num_q  <= '0;
      invalid_q      <= 1'b0;
      rm_q           <= FPU_RNE;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      out_number     <= '0;
      out_guard_bits <= '0;
      out_round_mode <= FPU_RNE;
      out_invalid    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      step_q         <= step_d;
      exp_q          <= exp_d;
      special_q      <= special_d;
      special_num_q  <= special_num_d;
      invalid_q      <= invalid_d;
      rm_q           <= rm_d;
      in_ready       <= in_ready_d;
      out_valid      <= out_valid_d;
      out_number     <= out_number_d;
      out_guard_bits <= out_guard_d;
      out_round_mode <= out_rm_d;
      out_invalid    <= out_invalid_d;
    end
  end

endmodule
